// File: rtl/seq_det_pkg.sv
// Shared types and limits for the serial pattern detector.
package seq_det_pkg;

    // Longest pattern the detector is qualified for.
    localparam int unsigned MAX_PAT_W = 16;

    // One-hot controller states.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        LOAD = 3'b010,
        SCAN = 3'b100
    } state_e;

endpackage : seq_det_pkg

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_det_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sat_q;
    logic             sat_d;

    // Next count: clear first, then increment unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
        sat_d = (count_d == CNT_MAX);
    end

    // Count and saturation flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule : seq_det_sat_cnt

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: compares the last PAT_W qualified bits against a
// pattern latched at start, pulses match and counts matches.
// Optional build macro SEQ_PATTERN_DETECTOR_MASK_EN adds a per-bit compare mask.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             din_valid,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
    input  logic [PAT_W-1:0] mask,
`endif
    input  logic             clr_cnt,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int unsigned     FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Reject pattern widths outside the qualified range at elaboration.
    if ((PAT_W < 2) || (PAT_W > MAX_PAT_W)) begin : g_bad_pat_w
        $error("seq_pattern_detector: PAT_W out of range");
    end

    // Plain vector so that corrupted (non one-hot) codes are representable
    // and can be steered back to IDLE.
    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  pat_d;
    logic              ovl_q;
    logic              ovl_d;
    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              busy_q;
    logic              busy_d;
    logic              match_q;
    logic              match_d;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
    logic [PAT_W-1:0]  mask_q;
    logic [PAT_W-1:0]  mask_d;
`endif

    logic [PAT_W-1:0]  hist_shift_c;
    logic [FILL_W-1:0] fill_inc_c;
    logic              cmp_hit_c;
    logic              full_c;

    // Candidate history/fill if the current bit is accepted, and the compare on it.
    always_comb begin
        hist_shift_c = {hist_q[PAT_W-2:0], din};
        fill_inc_c   = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_W'(1));
        full_c       = (fill_inc_c == FILL_FULL);
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        cmp_hit_c    = (((hist_shift_c ^ pat_q) & mask_q) == '0);
`else
        cmp_hit_c    = (hist_shift_c == pat_q);
`endif
    end

    // Controller: stop overrides everything, LOAD snapshots config, SCAN shifts and matches.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        mask_d  = mask_q;
`endif

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    pat_d   = pattern;
                    ovl_d   = overlap;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
                    mask_d  = mask;
`endif
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = SCAN;
                end
                SCAN: begin
                    if (din_valid) begin
                        hist_d = hist_shift_c;
                        fill_d = fill_inc_c;
                        if (full_c && cmp_hit_c) begin
                            match_d = 1'b1;
                            // Non-overlapping mode demands a full window of fresh bits.
                            if (!ovl_q) begin
                                fill_d = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == LOAD) || (state_d == SCAN);
    end

    // Controller, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            match_q <= match_d;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // Match counter advances on each visible match pulse.
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_q),
        .clr   (clr_cnt),
        .count (match_count),
        .sat   (cnt_sat)
    );

    assign busy  = busy_q;
    assign match = match_q;

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios followed by random traffic,
// all checked against a window-of-bits reference model.
module tb_seq_pattern_detector;

    localparam int unsigned PAT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       din_valid;
    logic       din;
    logic [3:0] pattern;
    logic       overlap;
    logic       clr_cnt;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
    logic [3:0] mask;
`endif

    logic       busy;
    logic       match;
    logic [7:0] match_count;
    logic       cnt_sat;
    logic       busy2;
    logic       match2;
    logic [1:0] count2;
    logic       sat2;

    int tests_run = 0;
    int fails     = 0;
    int pulses    = 0;

    // Reference model state
    int         m_phase;   // 0 idle, 1 load, 2 scan
    bit         m_q[$];    // bits accepted since the window was last emptied
    logic [3:0] m_pat;
    bit         m_ovl;
    bit         m_match;
    int         m_cnt8;
    int         m_cnt2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .din_valid(din_valid), .din(din), .pattern(pattern), .overlap(overlap),
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        .mask(mask),
`endif
        .clr_cnt(clr_cnt), .busy(busy), .match(match),
        .match_count(match_count), .cnt_sat(cnt_sat)
    );

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .din_valid(din_valid), .din(din), .pattern(pattern), .overlap(overlap),
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        .mask(mask),
`endif
        .clr_cnt(clr_cnt), .busy(busy2), .match(match2),
        .match_count(count2), .cnt_sat(sat2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic cycle();
        bit         nm;
        logic [3:0] w;
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            m_match = 1'b0;
            m_cnt8  = 0;
            m_cnt2  = 0;
        end else begin
            if (clr_cnt) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (m_match) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
            nm = 1'b0;
            if (stop) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (start) m_phase = 1;
            end else if (m_phase == 1) begin
                m_pat   = pattern;
                m_ovl   = overlap;
                m_q.delete();
                m_phase = 2;
            end else if (din_valid) begin
                m_q.push_back(din);
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                if (m_q.size() == PAT_W) begin
                    for (int i = 0; i < PAT_W; i++) w[i] = m_q[PAT_W-1-i];
                    if (w == m_pat) begin
                        nm = 1'b1;
                        if (!m_ovl) m_q.delete();
                    end
                end
            end
            m_match = nm;
        end
        #1;
        if (match) pulses++;
        chk("busy",        32'(busy),        32'(m_phase != 0));
        chk("match",       32'(match),       32'(m_match));
        chk("match_count", 32'(match_count), 32'(m_cnt8));
        chk("cnt_sat",     32'(cnt_sat),     32'(m_cnt8 == 255));
        chk("match_w2",    32'(match2),      32'(m_match));
        chk("count_w2",    32'(count2),      32'(m_cnt2));
        chk("sat_w2",      32'(sat2),        32'(m_cnt2 == 3));
    endtask

    task automatic do_load(input logic [3:0] p, input bit o);
        pattern = p;
        overlap = o;
        start   = 1'b1;
        cycle();
        start   = 1'b0;
        cycle();
    endtask

    task automatic feed(input bit b);
        din_valid = 1'b1;
        din       = b;
        cycle();
        din_valid = 1'b0;
    endtask

    task automatic feed_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) feed(bits[i]);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic clear_cnt();
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        rst = 1'b1; start = 1'b0; stop = 1'b0; din_valid = 1'b0; din = 1'b0;
        pattern = 4'h0; overlap = 1'b0; clr_cnt = 1'b0;
`ifdef SEQ_PATTERN_DETECTOR_MASK_EN
        mask = 4'hF;
`endif
        m_phase = 0; m_match = 1'b0; m_cnt8 = 0; m_cnt2 = 0; m_pat = 4'h0; m_ovl = 1'b0;

        // Reset values
        #1;
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_match", 32'(match),       32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        chk("rst_sat",   32'(cnt_sat),     32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Non-overlap 1011 over 1,1,0,1,1,0,1: window 1,0,1,1 completes on bit 5
        clear_cnt();
        do_load(4'b1011, 1'b0);
        pulses = 0;
        s = 16'b1101101;
        feed_seq(s, 7);
        cycle(); cycle();
        chk("A_pulses", 32'(pulses), 32'd1);
        chk("A_count",  32'(match_count), 32'd1);
        do_stop();

        // Overlap 1101 over same stream: matches after bits 4 and 7
        clear_cnt();
        do_load(4'b1101, 1'b1);
        pulses = 0;
        feed_seq(s, 7);
        cycle(); cycle();
        chk("B_pulses", 32'(pulses), 32'd2);
        chk("B_count",  32'(match_count), 32'd2);
        do_stop();

        // All-ones pattern, eight ones, overlap then non-overlap
        s = 16'h00FF;
        do_load(4'b1111, 1'b1);
        pulses = 0;
        feed_seq(s, 8);
        cycle();
        chk("C_ovl_pulses", 32'(pulses), 32'd5);
        do_stop();
        do_load(4'b1111, 1'b0);
        pulses = 0;
        feed_seq(s, 8);
        cycle();
        chk("C_novl_pulses", 32'(pulses), 32'd2);
        do_stop();

        // Valid toggling: invalid cycles carry junk that must be ignored
        do_load(4'b1011, 1'b0);
        pulses = 0;
        s = 16'b1011;
        for (int i = 3; i >= 0; i--) begin
            feed(s[i]);
            din = ~s[i];
            cycle();
        end
        chk("D_pulses", 32'(pulses), 32'd1);
        do_stop();

        // Narrow counter saturates; clear coincident with a match wins
        clear_cnt();
        do_load(4'b1111, 1'b1);
        s = 16'h00FF;
        feed_seq(s, 8);
        cycle(); cycle();
        chk("E_count_w2", 32'(count2), 32'd3);
        chk("E_sat_w2",   32'(sat2),   32'd1);
        feed(1'b1);
        chk("E_sixth_match", 32'(match), 32'd1);
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        chk("E_clr_wins", 32'(count2), 32'd0);
        do_stop();

        // Stop on the completing bit discards it
        do_load(4'b1111, 1'b1);
        pulses = 0;
        feed_seq(16'h0007, 3);
        din_valid = 1'b1; din = 1'b1; stop = 1'b1;
        cycle();
        din_valid = 1'b0; stop = 1'b0;
        chk("F_busy", 32'(busy), 32'd0);
        cycle();
        chk("F_pulses", 32'(pulses), 32'd0);

        // Async reset while a match pulse is visible
        do_load(4'b1111, 1'b1);
        feed_seq(16'h000F, 4);
        chk("G_pre_match", 32'(match), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("G_busy",  32'(busy),        32'd0);
        chk("G_match", 32'(match),       32'd0);
        chk("G_count", 32'(match_count), 32'd0);
        chk("G_sat",   32'(cnt_sat),     32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        do_load(4'b1111, 1'b1);
        chk("G_busy_scan", 32'(busy), 32'd1);
        pulses = 0;
        feed_seq(16'h0007, 3);
        chk("G_empty_hist", 32'(pulses), 32'd0);
        feed(1'b1);
        chk("G_first_match", 32'(pulses), 32'd1);
        do_stop();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            start     = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            stop      = ($urandom_range(0, 79) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
            din       = 1'($urandom);
            pattern   = 4'($urandom);
            overlap   = 1'($urandom);
            clr_cnt   = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_seq_pattern_detector
